// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the threshold FIFO.
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// W x DEPTH storage: one synchronous write port, one asynchronous read port, no reset.
// Read data is combinational from rd_addr; a write becomes visible the cycle after the edge.
module fifo_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/threshold_fifo.sv
// Synchronous FIFO with occupancy count, full/empty and programmable almost flags.
// STD mode: read data 1 cycle after an accepted read; FWFT: head word shown continuously. Rejected ops pulse overflow/underflow.
module threshold_fifo
   import fifo_pkg::*;
#(
   parameter int         MSB      = 7,
   parameter int         LSB      = 0,
   parameter int         DEPTH    = 16,
   parameter int         AF_LEVEL = DEPTH - 2,
   parameter int         AE_LEVEL = 1,
   parameter fifo_mode_e MODE     = FIFO_STD
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [MSB:LSB]           in,
   input  logic                     write,
   input  logic                     read,
   output logic [MSB:LSB]           out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int W  = MSB - LSB + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("threshold_fifo: DEPTH must be a power of two and at least 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("threshold_fifo: AF_LEVEL out of range 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("threshold_fifo: AE_LEVEL out of range 0..DEPTH-1");
   end

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [W-1:0]  rd_data;
   logic          wr_acc;
   logic          rd_acc;

   // A read on empty is refused even with a concurrent write; a write on full
   // is allowed only when a read frees the slot in the same cycle.
   assign rd_acc = read && !empty;
   assign wr_acc = write && (!full || rd_acc);

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   fifo_ram #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (in),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         overflow  <= write && !wr_acc;
         underflow <= read && !rd_acc;
      end
   end

   if (MODE == FIFO_STD) begin : g_std
      logic [W-1:0] out_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            out_q <= '0;
         end else if (rd_acc) begin
            out_q <= rd_data;
         end
      end

      assign out = out_q;
   end else begin : g_fwft
      assign out = rd_data;
   end

endmodule

// File: tb/tb_threshold_fifo.sv
// Bench for threshold_fifo: STD and FWFT instances share stimulus, checked against a queue model.
module tb_threshold_fifo;
   import fifo_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] din = '0;
   logic       write = 1'b0;
   logic       read = 1'b0;

   logic [7:0] s_out, f_out;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [2:0] s_count, f_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0] q[$];
   logic [7:0] m_std_out = '0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   always #5 clk = ~clk;

   threshold_fifo #(
      .MSB(7), .LSB(0), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1), .MODE(FIFO_STD)
   ) u_std (
      .clk(clk), .reset(reset), .in(din), .write(write), .read(read),
      .out(s_out), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   threshold_fifo #(
      .MSB(7), .LSB(0), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1), .MODE(FIFO_FWFT)
   ) u_fwft (
      .clk(clk), .reset(reset), .in(din), .write(write), .read(read),
      .out(f_out), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   // Drive one cycle, advance the model at the edge, settle 1 time unit past it.
   task automatic cycle(input logic rst, input logic w, input logic r, input logic [7:0] d);
      bit racc, wacc;
      reset = rst; write = w; read = r; din = d;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_std_out = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         racc = r && (q.size() != 0);
         wacc = w && ((q.size() != DEPTH) || racc);
         if (racc) m_std_out = q.pop_front();
         if (wacc) q.push_back(d);
         m_ovf = w && !wacc;
         m_unf = r && !racc;
      end
      #1;
      reset = 1'b0; write = 1'b0; read = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", s_count); end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", s_empty); end
      checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", s_full); end
      checks++; if (s_ae !== 1'b1) begin errors++; $display("FAIL reset_ae got %b want 1", s_ae); end
      checks++; if (s_af !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", s_af); end
      checks++; if ({s_ovf, s_unf} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {s_ovf, s_unf}); end
      checks++; if (s_out !== 8'h00) begin errors++; $display("FAIL reset_std_out got %h want 00", s_out); end
      checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft_empty got %b want 1", f_empty); end
   endtask

   task automatic test_fill();
      logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, vals[i]);
         checks++; if (s_count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, s_count, i + 1); end
         checks++; if (s_af !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_af[%0d] got %b want %b", i, s_af, (i + 1 >= 3)); end
         checks++; if (s_full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, s_full, (i == 3)); end
      end
      checks++; if (f_out !== 8'h11) begin errors++; $display("FAIL fill_fwft_head got %h want 11", f_out); end
   endtask

   task automatic test_overflow_drain();
      logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      cycle(1'b0, 1'b1, 1'b0, 8'h55);
      checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", s_ovf); end
      checks++; if (s_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", s_count); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (f_out !== vals[i]) begin errors++; $display("FAIL drain_fwft[%0d] got %h want %h", i, f_out, vals[i]); end
         cycle(1'b0, 1'b0, 1'b1, 8'h00);
         checks++; if (s_out !== vals[i]) begin errors++; $display("FAIL drain_std[%0d] got %h want %h", i, s_out, vals[i]); end
         if (i == 0) begin
            checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", s_ovf); end
         end
      end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", s_empty); end
   endtask

   task automatic test_underflow();
      cycle(1'b0, 1'b1, 1'b1, 8'hA5);
      checks++; if (s_unf !== 1'b1) begin errors++; $display("FAIL unf_pulse got %b want 1", s_unf); end
      checks++; if (s_count !== 3'd1) begin errors++; $display("FAIL unf_count got %0d want 1", s_count); end
      checks++; if (f_out !== 8'hA5) begin errors++; $display("FAIL unf_fwft got %h want a5", f_out); end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      checks++; if (s_out !== 8'hA5) begin errors++; $display("FAIL unf_read got %h want a5", s_out); end
      checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", s_unf); end
   endtask

   task automatic test_full_rw();
      logic [7:0] fill[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] exp[4]  = '{8'h22, 8'h33, 8'h44, 8'h66};
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, fill[i]);
      cycle(1'b0, 1'b1, 1'b1, 8'h66);
      checks++; if (s_count !== 3'd4) begin errors++; $display("FAIL frw_count got %0d want 4", s_count); end
      checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL frw_ovf got %b want 0", s_ovf); end
      checks++; if (s_out !== 8'h11) begin errors++; $display("FAIL frw_out got %h want 11", s_out); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (f_out !== exp[i]) begin errors++; $display("FAIL frw_fwft[%0d] got %h want %h", i, f_out, exp[i]); end
         cycle(1'b0, 1'b0, 1'b1, 8'h00);
         checks++; if (s_out !== exp[i]) begin errors++; $display("FAIL frw_std[%0d] got %h want %h", i, s_out, exp[i]); end
      end
   endtask

   task automatic test_fwft_first();
      cycle(1'b0, 1'b1, 1'b0, 8'hC3);
      checks++; if (f_out !== 8'hC3) begin errors++; $display("FAIL fwft_first got %h want c3", f_out); end
      checks++; if (f_empty !== 1'b0) begin errors++; $display("FAIL fwft_empty got %b want 0", f_empty); end
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_reset_write();
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
      checks++; if (s_count !== 3'd3) begin errors++; $display("FAIL rw_pre_count got %0d want 3", s_count); end
      cycle(1'b1, 1'b1, 1'b0, 8'hEE);
      checks++; if (s_count !== 3'd0) begin errors++; $display("FAIL rw_count got %0d want 0", s_count); end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL rw_empty got %b want 1", s_empty); end
      checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL rw_ovf got %b want 0", s_ovf); end
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      checks++; if (f_count !== 3'd0) begin errors++; $display("FAIL rw_after got %0d want 0", f_count); end
   endtask

   task automatic test_random();
      logic       w, r, rst;
      logic [2:0] m_cnt;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         w   = ($urandom_range(0, 99) < 55);
         r   = ($urandom_range(0, 99) < 50);
         cycle(rst, w, r, 8'($urandom));
         m_cnt = 3'(q.size());
         checks++; if (s_count !== m_cnt || f_count !== m_cnt) begin errors++; $display("FAIL rnd_count[%0d] got %0d/%0d want %0d", n, s_count, f_count, m_cnt); end
         checks++; if ({s_full, s_empty, s_af, s_ae} !== {m_cnt == 4, m_cnt == 0, m_cnt >= 3, m_cnt <= 1}) begin
            errors++; $display("FAIL rnd_flags[%0d] got %b want %b", n, {s_full, s_empty, s_af, s_ae}, {m_cnt == 4, m_cnt == 0, m_cnt >= 3, m_cnt <= 1}); end
         checks++; if ({s_ovf, s_unf, f_ovf, f_unf} !== {m_ovf, m_unf, m_ovf, m_unf}) begin
            errors++; $display("FAIL rnd_pulses[%0d] got %b want %b", n, {s_ovf, s_unf, f_ovf, f_unf}, {m_ovf, m_unf, m_ovf, m_unf}); end
         checks++; if (s_out !== m_std_out) begin errors++; $display("FAIL rnd_std_out[%0d] got %h want %h", n, s_out, m_std_out); end
         if (q.size() != 0) begin
            checks++; if (f_out !== q[0]) begin errors++; $display("FAIL rnd_fwft_out[%0d] got %h want %h", n, f_out, q[0]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow_drain();
      test_underflow();
      test_full_rw();
      test_fwft_first();
      test_reset_write();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/threshold_fifo.md
THRESHOLD_FIFO -- requirements
Module: threshold_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MSB, 7, data MSB index.
- LSB, 0, data LSB index; width W = MSB-LSB+1.
- DEPTH, 16, entries; power of two, at least 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- MODE, FIFO_STD, FIFO_STD (registered read) or FIFO_FWFT (first-word-fall-through).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; rising edge.
- reset, input, 1, synchronous, active-high.
- in, input, [MSB:LSB], write data.
- write, input, 1, push request.
- read, input, 1, pop request.
- out, output, [MSB:LSB], read data.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AF_LEVEL.
- almost_empty, output, 1, count <= AE_LEVEL.
- count, output, $clog2(DEPTH)+1, current occupancy.
- overflow, output, 1, one-cycle pulse for a rejected write.
- underflow, output, 1, one-cycle pulse for a rejected read.

Function
REQ-003 A write SHALL be accepted when write=1 and (full=0, or read is accepted in the same cycle).
REQ-004 A read SHALL be accepted when read=1 and empty=0; a read on empty SHALL be rejected even if write=1 in the same cycle.
REQ-005 Accepted write: mem[wr_ptr] <= in; wr_ptr increments modulo DEPTH (wrap from DEPTH-1 to 0).
REQ-006 Accepted read: rd_ptr increments modulo DEPTH.
REQ-007 count SHALL be a register: +1 for write only, -1 for read only, unchanged when both or neither are accepted.
REQ-008 full, empty, almost_full and almost_empty SHALL decode combinationally from the count register, so they reflect an operation in the following cycle.
REQ-009 Rejected write: data dropped, no state change; overflow=1 for exactly the next cycle.
REQ-010 Rejected read: no state change; underflow=1 for exactly the next cycle.
REQ-011 FIFO_STD: on an accepted read, out <= mem[rd_ptr] (1-cycle latency); otherwise out holds its value.
REQ-012 FIFO_FWFT: out = mem[rd_ptr] continuously; it is valid whenever empty=0; an accepted read advances to the next word in the next cycle.
REQ-013 FIFO_FWFT write into an empty FIFO: the word SHALL appear on out in the cycle after the write.
REQ-014 Full with read=1 and write=1: both accepted; count stays DEPTH; overflow=0.
REQ-015 Elaboration SHALL fail on DEPTH not a power of two, DEPTH < 2, or AF_LEVEL/AE_LEVEL out of range.

Reset
REQ-016 reset=1 at a clk edge SHALL clear wr_ptr, rd_ptr, count, overflow, underflow and (FIFO_STD) out to 0; memory contents are not cleared.
REQ-017 After reset: empty=1, full=0, almost_empty=1, almost_full=0.
REQ-018 reset SHALL dominate write and read in the same cycle; data in flight mid-operation is discarded.

Structure
REQ-019 Package fifo_pkg SHALL hold the enum fifo_mode_e {FIFO_STD, FIFO_FWFT}.
REQ-020 Storage SHALL be a sub-module fifo_ram: W x DEPTH, one write port, one asynchronous read port, no reset.
REQ-021 threshold_fifo SHALL contain the pointers, count, flags and output register.

Verification (W=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-022 STD: write 8'h11, 8'h22, 8'h33, 8'h44 -> full=1 and count=4 the cycle after the 4th write; almost_full=1 from count=3.
REQ-023 Full, write 8'h55 -> overflow pulses 1 cycle; draining returns 8'h11, 8'h22, 8'h33, 8'h44, each 1 cycle after its read; no 8'h55.
REQ-024 Empty, read=1 and write=1 with 8'hA5 -> underflow pulses; count=1; next read returns 8'hA5.
REQ-025 Full, read and write 8'h66 simultaneously -> count stays 4; 8'h66 is read last after 8'h22, 8'h33, 8'h44; pointers wrap correctly.
REQ-026 FWFT: write 8'hC3 to empty -> out=8'hC3 and empty=0 next cycle, with no read issued.
REQ-027 With count=3, assert reset together with write -> next cycle count=0, empty=1, overflow=0, write ignored.
